// File: rtl/bitonic_sort_pipe.sv
// Streaming bitonic sorter: one compare level per register stage, one vector per cycle.
// Optional macro SORT_IDX_EN adds idx_o (original word positions) and tie-breaks on index.
module bitonic_sort_pipe #(
    parameter int LP = 3,
    parameter int dw = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [(2**LP)*dw-1:0]      d_i,
    input  logic                       desc_i,
    input  logic                       req_i,
    output logic                       ack_i,
    output logic [(2**LP)*dw-1:0]      d_o,
    output logic                       desc_o,
    output logic                       req_o,
    input  logic                       ack_o,
`ifdef SORT_IDX_EN
    output logic [(2**LP)*LP-1:0]      idx_o,
`endif
    output logic                       busy
);

    localparam int N  = 2**LP;
    localparam int S  = LP*(LP+1)/2;
    localparam int VW = N*dw;
`ifdef SORT_IDX_EN
    localparam int KW = dw + LP;
`else
    localparam int KW = dw;
`endif

    logic [S-1:0][VW-1:0] data_q, data_nxt;
    logic [S-1:0]         desc_q, desc_nxt;
    logic [S-1:0]         valid_q, valid_nxt;
    logic                 stall;

`ifdef SORT_IDX_EN
    logic [S-1:0][N*LP-1:0] tag_q, tag_nxt;

    function automatic logic [N*LP-1:0] init_tags();
        logic [N*LP-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) begin
            t[i*LP +: LP] = LP'(i);
        end
        return t;
    endfunction
`endif

    assign stall = valid_q[S-1] & ~ack_o;
    assign ack_i = ~stall;

    // Stage SI applies compare level (block 2**k, distance 2**J) to the previous stage.
    for (genvar k = 1; k <= LP; k++) begin : g_blk
        for (genvar jj = 0; jj < k; jj++) begin : g_lvl
            localparam int SI = (k-1)*k/2 + jj;
            localparam int J  = k-1-jj;

            logic [VW-1:0] cur, nxt;
            logic          cur_desc;
            logic [KW-1:0] ka, kb;
            logic          dir;
`ifdef SORT_IDX_EN
            logic [N*LP-1:0] cur_tag, nxt_tag;
`endif

            if (SI == 0) begin : g_first
                assign cur          = d_i;
                assign cur_desc     = desc_i;
                assign valid_nxt[SI] = req_i & ack_i;
`ifdef SORT_IDX_EN
                assign cur_tag      = init_tags();
`endif
            end else begin : g_rest
                assign cur          = data_q[SI-1];
                assign cur_desc     = desc_q[SI-1];
                assign valid_nxt[SI] = valid_q[SI-1];
`ifdef SORT_IDX_EN
                assign cur_tag      = tag_q[SI-1];
`endif
            end

            always_comb begin
                nxt = cur;
                ka  = '0;
                kb  = '0;
                dir = 1'b0;
`ifdef SORT_IDX_EN
                nxt_tag = cur_tag;
`endif
                for (int i = 0; i < N; i++) begin
                    if (((i >> J) & 1) == 0) begin
`ifdef SORT_IDX_EN
                        ka = {cur[i*dw +: dw], cur_tag[i*LP +: LP]};
                        kb = {cur[(i+(1<<J))*dw +: dw], cur_tag[(i+(1<<J))*LP +: LP]};
`else
                        ka = cur[i*dw +: dw];
                        kb = cur[(i+(1<<J))*dw +: dw];
`endif
                        // Only the final merge takes the vector's own order.
                        dir = (k == LP) ? cur_desc : (((i >> k) & 1) == 1);
                        if (dir ? (ka < kb) : (ka > kb)) begin
                            nxt[i*dw +: dw]          = cur[(i+(1<<J))*dw +: dw];
                            nxt[(i+(1<<J))*dw +: dw] = cur[i*dw +: dw];
`ifdef SORT_IDX_EN
                            nxt_tag[i*LP +: LP]          = cur_tag[(i+(1<<J))*LP +: LP];
                            nxt_tag[(i+(1<<J))*LP +: LP] = cur_tag[i*LP +: LP];
`endif
                        end
                    end
                end
            end

            assign data_nxt[SI] = nxt;
            assign desc_nxt[SI] = cur_desc;
`ifdef SORT_IDX_EN
            assign tag_nxt[SI]  = nxt_tag;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            desc_q  <= '0;
            valid_q <= '0;
`ifdef SORT_IDX_EN
            tag_q   <= '0;
`endif
        end else if (!stall) begin
            data_q  <= data_nxt;
            desc_q  <= desc_nxt;
            valid_q <= valid_nxt;
`ifdef SORT_IDX_EN
            tag_q   <= tag_nxt;
`endif
        end
    end

    assign d_o    = data_q[S-1];
    assign desc_o = desc_q[S-1];
    assign req_o  = valid_q[S-1];
    assign busy   = |valid_q;
`ifdef SORT_IDX_EN
    assign idx_o  = tag_q[S-1];
`endif

endmodule
